// File: rtl/run_ctrl_pkg.sv
// Shared state encoding and configuration legality check for run_controller.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD    = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } run_state_e;

    function automatic bit cfg_legal(input int timeout, input int rst_hold,
                                     input int stall_lim, input int cnt_w);
        return (timeout >= 1) && (rst_hold >= 1) && (stall_lim >= 2)
            && ((cnt_w >= 31) || (timeout < (1 << cnt_w)));
    endfunction

endpackage

// File: rtl/pc_stall_detector.sv
// Flags a PC that has held the same value for STALL_LIM consecutive RUN samples.
// Flag is combinational from the current pc; no backpressure, counter clears whenever run is low.
module pc_stall_detector #(
    parameter int PC_W      = 6,
    parameter int STALL_LIM = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [PC_W-1:0] pc,
    output logic            stall
);
    localparam int SCNT_W = $clog2(STALL_LIM + 1);

    logic [PC_W-1:0]   prev_pc_q, prev_pc_d;
    logic [SCNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        prev_pc_d = prev_pc_q;
        cnt_d     = '0;
        if (run) begin
            prev_pc_d = pc;
            // A zero count marks the first RUN sample, which has nothing to compare against.
            if (cnt_q == '0 || pc != prev_pc_q) begin
                cnt_d = SCNT_W'(1);
            end else if (cnt_q != SCNT_W'(STALL_LIM)) begin
                cnt_d = cnt_q + SCNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    assign stall = run && (cnt_d == SCNT_W'(STALL_LIM));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_pc_q <= '0;
            cnt_q     <= '0;
        end else begin
            prev_pc_q <= prev_pc_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/run_controller.sv
// Sequences core reset, counts RUN cycles, ends a run on halt/PC stall/watchdog and snapshots registers.
// All outputs registered; snap_valid trails halt detection by 2 cycles; no backpressure, abort preempts all.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int PC_W      = 6,
    parameter int REG_W     = 32,
    parameter int NREGS     = 6,
    parameter int CNT_W     = 32,
    parameter int TIMEOUT   = 1001,
    parameter int RST_HOLD  = 2,
    parameter int STALL_LIM = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   halt_req,
    input  logic [PC_W-1:0]        pc,
    input  logic [NREGS*REG_W-1:0] regs_flat,
    output logic                   core_rst_n,
    output logic                   busy,
    output logic                   done,
    output logic                   timed_out,
    output logic [CNT_W-1:0]       cycles,
    output logic [NREGS*REG_W-1:0] snap_regs,
    output logic                   snap_valid
);
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    run_state_e               state_q, state_d;
    logic [HOLD_W-1:0]        hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]         cycles_q, cycles_d, cycles_inc;
    logic                     timed_out_q, timed_out_d;
    logic [NREGS*REG_W-1:0]   snap_regs_q, snap_regs_d;
    logic                     snap_valid_q, snap_valid_d;
    logic                     core_rst_n_q, core_rst_n_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     in_run, stall, watchdog;

    assign in_run     = (state_q == RUN);
    assign cycles_inc = (cycles_q == {CNT_W{1'b1}}) ? cycles_q : cycles_q + CNT_W'(1);
    assign watchdog   = (cycles_inc >= CNT_W'(TIMEOUT));

    pc_stall_detector #(
        .PC_W      (PC_W),
        .STALL_LIM (STALL_LIM)
    ) u_stall (
        .clk   (clk),
        .rst   (rst),
        .run   (in_run),
        .pc    (pc),
        .stall (stall)
    );

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        cycles_d     = cycles_q;
        timed_out_d  = timed_out_q;
        snap_regs_d  = snap_regs_q;
        snap_valid_d = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d     = HOLD;
                        hold_cnt_d  = HOLD_W'(RST_HOLD - 1);
                        cycles_d    = '0;
                        timed_out_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end
                end
                RUN: begin
                    cycles_d = cycles_inc;
                    // A halt in the watchdog cycle still counts as a clean halt.
                    if (halt_req || stall) begin
                        state_d     = CAPTURE;
                        timed_out_d = 1'b0;
                    end else if (watchdog) begin
                        state_d     = CAPTURE;
                        timed_out_d = 1'b1;
                    end
                end
                CAPTURE: begin
                    state_d      = DONE;
                    snap_regs_d  = regs_flat;
                    snap_valid_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        core_rst_n_d = (state_d == RUN) || (state_d == CAPTURE) || (state_d == DONE);
        busy_d       = (state_d == HOLD) || (state_d == RUN) || (state_d == CAPTURE);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            cycles_q     <= '0;
            timed_out_q  <= 1'b0;
            snap_regs_q  <= '0;
            snap_valid_q <= 1'b0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            cycles_q     <= cycles_d;
            timed_out_q  <= timed_out_d;
            snap_regs_q  <= snap_regs_d;
            snap_valid_q <= snap_valid_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign core_rst_n = core_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timed_out  = timed_out_q;
    assign cycles     = cycles_q;
    assign snap_regs  = snap_regs_q;
    assign snap_valid = snap_valid_q;

`ifdef SIM
    always_ff @(posedge clk) begin
        assert (cfg_legal(TIMEOUT, RST_HOLD, STALL_LIM, CNT_W))
            else $error("run_controller: illegal parameter set");
    end
`endif

endmodule

// File: tb/tb_run_controller.sv
// Randomized self-checking bench for run_controller against a run-outcome reference model.
module tb_run_controller;
    localparam int PC_W      = 6;
    localparam int REG_W     = 32;
    localparam int NREGS     = 6;
    localparam int CNT_W     = 32;
    localparam int TIMEOUT   = 1001;
    localparam int RST_HOLD  = 2;
    localparam int STALL_LIM = 3;
    localparam int DW        = NREGS * REG_W;
    localparam int MAXK      = TIMEOUT + 10;

    logic             clk = 1'b0;
    logic             rst, start, abort, halt_req;
    logic [PC_W-1:0]  pc;
    logic [DW-1:0]    regs_flat;
    logic             core_rst_n, busy, done, timed_out, snap_valid;
    logic [CNT_W-1:0] cycles;
    logic [DW-1:0]    snap_regs;

    int checks = 0;
    int errors = 0;

    // Per-run stimulus, indexed by RUN cycle number (1 = first RUN cycle).
    logic [PC_W-1:0] pc_seq    [0:MAXK];
    bit              halt_seq  [0:MAXK];
    logic [DW-1:0]   regs_hist [0:MAXK];

    int               o_hold, o_done_at, o_sv_cnt, o_sv_first;
    logic [CNT_W-1:0] o_cyc, o_h_cyc, o_ab_cyc;
    logic             o_to, o_h_to, o_h_busy, o_h_done;
    logic             o_ab_rstn, o_ab_busy, o_ab_done, o_ab_to;
    logic [DW-1:0]    o_snap, o_ab_snap;

    run_controller #(
        .PC_W(PC_W), .REG_W(REG_W), .NREGS(NREGS), .CNT_W(CNT_W),
        .TIMEOUT(TIMEOUT), .RST_HOLD(RST_HOLD), .STALL_LIM(STALL_LIM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .halt_req   (halt_req),
        .pc         (pc),
        .regs_flat  (regs_flat),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .timed_out  (timed_out),
        .cycles     (cycles),
        .snap_regs  (snap_regs),
        .snap_valid (snap_valid)
    );

    always #5 clk = ~clk;

    // mode 0: incrementing pc, 1: toggling pc, 2: random pc, 3: random pc in a tiny range
    task automatic fill_pc(input int mode);
        for (int k = 0; k <= MAXK; k++) begin
            halt_seq[k] = 1'b0;
            case (mode)
                0:       pc_seq[k] = PC_W'(k);
                1:       pc_seq[k] = PC_W'(k % 2);
                2:       pc_seq[k] = PC_W'($urandom);
                default: pc_seq[k] = PC_W'($urandom_range(0, 3));
            endcase
        end
    endtask

    // Run ends at the first RUN cycle with a halt request or STALL_LIM equal trailing pcs,
    // otherwise at the TIMEOUT-th cycle, which is then a watchdog ending.
    function automatic void ref_end(output int end_k, output bit to);
        bit stuck;
        end_k = -1;
        to    = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            stuck = (k >= STALL_LIM);
            for (int j = 1; j < STALL_LIM; j++)
                if (pc_seq[k - j] != pc_seq[k]) stuck = 1'b0;
            if (halt_seq[k] || stuck) begin
                end_k = k;
                return;
            end
            if (k == TIMEOUT) begin
                end_k = k;
                to    = 1'b1;
                return;
            end
        end
    endfunction

    // Acts as the core: pulses start, plays pc_seq/halt_seq once reset is released, records outputs.
    task automatic run_core(input int abort_at);
        o_hold = 0; o_done_at = -1; o_sv_cnt = 0; o_sv_first = -1;
        o_cyc = 'x; o_to = 1'bx; o_snap = 'x;
        o_ab_rstn = 1'bx; o_ab_busy = 1'bx; o_ab_done = 1'bx; o_ab_to = 1'bx;
        o_ab_cyc = 'x; o_ab_snap = 'x;
        pc    = pc_seq[0];
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        o_h_cyc  = cycles;
        o_h_to   = timed_out;
        o_h_busy = busy;
        o_h_done = done;
        while (core_rst_n == 1'b0 && o_hold < 20) begin
            o_hold++;
            @(negedge clk);
        end
        for (int k = 1; k < MAXK; k++) begin
            pc       = pc_seq[k];
            halt_req = halt_seq[k];
            abort    = (k == abort_at);
            for (int i = 0; i < NREGS; i++) regs_flat[i*REG_W +: REG_W] = $urandom;
            regs_hist[k] = regs_flat;
            @(negedge clk);
            if (snap_valid === 1'b1) begin
                o_sv_cnt++;
                if (o_sv_first < 0) o_sv_first = k + 1;
            end
            if (k == abort_at) begin
                o_ab_rstn = core_rst_n; o_ab_busy = busy; o_ab_done = done;
                o_ab_to = timed_out; o_ab_cyc = cycles; o_ab_snap = snap_regs;
                break;
            end
            if (done === 1'b1) begin
                o_done_at = k + 1;
                o_cyc = cycles; o_to = timed_out; o_snap = snap_regs;
                break;
            end
        end
        halt_req = 1'b0;
        abort    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (snap_valid === 1'b1) o_sv_cnt++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; abort = 1'b0; halt_req = 1'b0; pc = '0; regs_flat = '0;
        repeat (3) @(negedge clk);
        checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL reset_core_rst_n: got %b expected 0", core_rst_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL reset_timed_out: got %b expected 0", timed_out); end
        checks++; if (cycles !== '0) begin errors++; $display("FAIL reset_cycles: got %0d expected 0", cycles); end
        checks++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL reset_snap_valid: got %b expected 0", snap_valid); end
        checks++; if (snap_regs !== '0) begin errors++; $display("FAIL reset_snap_regs: got %h expected 0", snap_regs); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({core_rst_n, busy, done} !== 3'b000) begin errors++; $display("FAIL idle_outputs: got %b expected 000", {core_rst_n, busy, done}); end
    endtask

    task automatic test_halt_req;
        int e_end, idx;
        bit e_to;
        for (int n = 0; n < 5; n++) begin
            fill_pc(n == 0 ? 0 : 2);
            idx = (n == 0) ? 10 : $urandom_range(2, 80);
            halt_seq[idx] = 1'b1;
            ref_end(e_end, e_to);
            run_core(0);
            checks++; if (o_hold != RST_HOLD) begin errors++; $display("FAIL halt_hold_len run %0d: got %0d expected %0d", n, o_hold, RST_HOLD); end
            checks++; if (o_done_at != e_end + 2) begin errors++; $display("FAIL halt_done_latency run %0d: got %0d expected %0d", n, o_done_at, e_end + 2); end
            checks++; if (o_cyc !== CNT_W'(e_end)) begin errors++; $display("FAIL halt_cycles run %0d: got %0d expected %0d", n, o_cyc, e_end); end
            checks++; if (o_to !== e_to) begin errors++; $display("FAIL halt_timed_out run %0d: got %b expected %b", n, o_to, e_to); end
            checks++; if (o_sv_cnt != 1 || o_sv_first != e_end + 2) begin errors++; $display("FAIL halt_snap_valid run %0d: got %0d pulses first at %0d expected 1 at %0d", n, o_sv_cnt, o_sv_first, e_end + 2); end
            checks++; if (o_snap !== regs_hist[e_end + 1]) begin errors++; $display("FAIL halt_snap_regs run %0d: got %h expected %h", n, o_snap, regs_hist[e_end + 1]); end
        end
    endtask

    task automatic test_stall;
        int e_end;
        bit e_to;
        for (int n = 0; n < 5; n++) begin
            if (n == 0) begin
                fill_pc(0);
                for (int k = 5; k <= MAXK; k++) pc_seq[k] = 6'h14;
            end else begin
                fill_pc(3);
            end
            ref_end(e_end, e_to);
            run_core(0);
            checks++; if (o_done_at != e_end + 2) begin errors++; $display("FAIL stall_done_latency run %0d: got %0d expected %0d", n, o_done_at, e_end + 2); end
            checks++; if (o_cyc !== CNT_W'(e_end)) begin errors++; $display("FAIL stall_cycles run %0d: got %0d expected %0d", n, o_cyc, e_end); end
            checks++; if (o_to !== e_to) begin errors++; $display("FAIL stall_timed_out run %0d: got %b expected %b", n, o_to, e_to); end
            checks++; if (o_sv_cnt != 1 || o_snap !== regs_hist[e_end + 1]) begin errors++; $display("FAIL stall_snapshot run %0d: got %0d pulses data %h expected 1 pulse data %h", n, o_sv_cnt, o_snap, regs_hist[e_end + 1]); end
        end
    endtask

    // Second pass leaves the controller in DONE with timed_out set for the back-to-back test.
    task automatic test_watchdog;
        int e_end;
        bit e_to;
        for (int n = 0; n < 2; n++) begin
            fill_pc(1);
            if (n == 0) halt_seq[TIMEOUT] = 1'b1;
            ref_end(e_end, e_to);
            run_core(0);
            checks++; if (o_done_at != e_end + 2) begin errors++; $display("FAIL wdog_done_latency run %0d: got %0d expected %0d", n, o_done_at, e_end + 2); end
            checks++; if (o_cyc !== CNT_W'(e_end)) begin errors++; $display("FAIL wdog_cycles run %0d: got %0d expected %0d", n, o_cyc, e_end); end
            checks++; if (o_to !== e_to) begin errors++; $display("FAIL wdog_timed_out run %0d: got %b expected %b", n, o_to, e_to); end
            checks++; if (o_sv_cnt != 1 || o_snap !== regs_hist[e_end + 1]) begin errors++; $display("FAIL wdog_snapshot run %0d: got %0d pulses data %h expected 1 pulse data %h", n, o_sv_cnt, o_snap, regs_hist[e_end + 1]); end
        end
    endtask

    task automatic test_back_to_back;
        int e_end, idx;
        bit e_to;
        for (int n = 0; n < 3; n++) begin
            fill_pc(n == 0 ? 1 : 3);
            idx = $urandom_range(2, 40);
            halt_seq[idx] = 1'b1;
            ref_end(e_end, e_to);
            run_core(0);
            checks++; if (o_h_cyc !== '0 || o_h_to !== 1'b0) begin errors++; $display("FAIL b2b_cleared run %0d: got cycles %0d timed_out %b expected 0 0", n, o_h_cyc, o_h_to); end
            checks++; if (o_h_busy !== 1'b1 || o_h_done !== 1'b0) begin errors++; $display("FAIL b2b_hold_flags run %0d: got busy %b done %b expected 1 0", n, o_h_busy, o_h_done); end
            checks++; if (o_hold != RST_HOLD) begin errors++; $display("FAIL b2b_hold_len run %0d: got %0d expected %0d", n, o_hold, RST_HOLD); end
            checks++; if (o_done_at != e_end + 2 || o_cyc !== CNT_W'(e_end)) begin errors++; $display("FAIL b2b_end run %0d: got done at %0d cycles %0d expected %0d and %0d", n, o_done_at, o_cyc, e_end + 2, e_end); end
            checks++; if (o_to !== e_to || o_sv_cnt != 1) begin errors++; $display("FAIL b2b_status run %0d: got timed_out %b pulses %0d expected %b and 1", n, o_to, o_sv_cnt, e_to); end
            checks++; if (o_snap !== regs_hist[e_end + 1]) begin errors++; $display("FAIL b2b_snap_regs run %0d: got %h expected %h", n, o_snap, regs_hist[e_end + 1]); end
        end
    endtask

    task automatic test_abort;
        int e_end, idx, ab;
        bit e_to;
        logic [DW-1:0] e_snap;
        fill_pc(2);
        idx = $urandom_range(5, 40);
        halt_seq[idx] = 1'b1;
        ref_end(e_end, e_to);
        run_core(0);
        e_snap = regs_hist[e_end + 1];
        for (int n = 0; n < 2; n++) begin
            ab = (n == 0) ? 51 : $urandom_range(2, 300);
            fill_pc(0);
            run_core(ab);
            checks++; if (o_ab_rstn !== 1'b0) begin errors++; $display("FAIL abort_core_rst_n run %0d: got %b expected 0", n, o_ab_rstn); end
            checks++; if ({o_ab_busy, o_ab_done} !== 2'b00) begin errors++; $display("FAIL abort_idle run %0d: got busy/done %b expected 00", n, {o_ab_busy, o_ab_done}); end
            checks++; if (o_ab_cyc !== CNT_W'(ab - 1)) begin errors++; $display("FAIL abort_cycles run %0d: got %0d expected %0d", n, o_ab_cyc, ab - 1); end
            checks++; if (o_ab_to !== 1'b0) begin errors++; $display("FAIL abort_timed_out run %0d: got %b expected 0", n, o_ab_to); end
            checks++; if (o_ab_snap !== e_snap) begin errors++; $display("FAIL abort_snap_regs run %0d: got %h expected %h", n, o_ab_snap, e_snap); end
            checks++; if (o_sv_cnt != 0) begin errors++; $display("FAIL abort_snap_valid run %0d: got %0d pulses expected 0", n, o_sv_cnt); end
        end
    endtask

    task automatic test_reset_mid_run;
        fill_pc(0);
        pc    = pc_seq[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= RST_HOLD + 8; k++) begin
            pc = pc_seq[k];
            @(negedge clk);
        end
        checks++; if (busy !== 1'b1 || core_rst_n !== 1'b1 || cycles === '0) begin errors++; $display("FAIL midrun_running: got busy %b core_rst_n %b cycles %0d expected 1 1 nonzero", busy, core_rst_n, cycles); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({core_rst_n, busy, done, timed_out, snap_valid} !== 5'b0) begin errors++; $display("FAIL midrun_reset_flags: got %b expected 00000", {core_rst_n, busy, done, timed_out, snap_valid}); end
        checks++; if (cycles !== '0 || snap_regs !== '0) begin errors++; $display("FAIL midrun_reset_data: got cycles %0d snap %h expected 0 0", cycles, snap_regs); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_halt_req;
        test_stall;
        test_watchdog;
        test_back_to_back;
        test_abort;
        test_reset_mid_run;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected finish within 2 ms");
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Synthesizable run controller that replaces ad-hoc bench timing around the processor.
- Sequences core reset, counts consumed cycles, and detects program halt (explicit request or PC stall).
- Enforces a watchdog timeout and snapshots a parametrised set of architectural registers at end of run.
- Sits between the bench/FPGA top and the processor's reset, PC and register-probe ports.

Parameters:
PC_W, 6, width of observed program counter
REG_W, 32, width of each probed register
NREGS, 6, number of probed registers
CNT_W, 32, cycle counter width
TIMEOUT, 1001, max RUN cycles before watchdog fires (>=1)
RST_HOLD, 2, cycles core reset held low after start (>=1)
STALL_LIM, 3, consecutive unchanged-PC cycles that count as halt (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  begin run; honoured in IDLE and DONE only
abort  in  1  force return to IDLE from any state
halt_req  in  1  core asserts on halt instruction
pc  in  PC_W  core program counter
regs_flat  in  NREGS*REG_W  probed registers, reg i at bits [i*REG_W +: REG_W]
core_rst_n  out  1  active-low reset to the core
busy  out  1  high in HOLD, RUN, CAPTURE
done  out  1  high in DONE
timed_out  out  1  run ended by watchdog
cycles  out  CNT_W  RUN cycles consumed
snap_regs  out  NREGS*REG_W  captured register values
snap_valid  out  1  one-cycle pulse when snap_regs updates

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, core_rst_n=0, cycles=0, hold/stall counters=0.
  - timed_out=0, snap_regs=0, snap_valid=0, busy=0, done=0.
- States: IDLE, HOLD, RUN, CAPTURE, DONE. All outputs are registered.
- IDLE:
  - core_rst_n=0.
  - start=1 -> HOLD; clear cycles and timed_out, load hold counter.
- HOLD:
  - core_rst_n=0 for exactly RST_HOLD cycles, then -> RUN.
  - core_rst_n rises on the first RUN cycle.
- RUN:
  - core_rst_n=1; cycles increments each cycle, saturating at all-ones.
  - Stall counter: reset to 1 when pc != previous pc, incremented otherwise, saturating at STALL_LIM. The previous-pc register is loaded every RUN cycle; its first compare uses the pc sampled in the first RUN cycle.
  - Halt: halt_req=1, or stall counter reaches STALL_LIM -> CAPTURE with timed_out=0.
  - Watchdog: cycles reaches TIMEOUT with no halt in that cycle -> CAPTURE with timed_out=1.
  - Halt and watchdog in the same cycle: halt wins, timed_out=0.
  - start ignored.
- CAPTURE (1 cycle):
  - snap_regs<=regs_flat, snap_valid=1 next cycle, core_rst_n stays 1 (core state intact), cycles frozen -> DONE.
- DONE:
  - cycles, timed_out, snap_regs held; core_rst_n=1.
  - start=1 -> HOLD (new run, counters cleared).
- abort=1 in any state:
  - next state IDLE, core_rst_n=0.
  - cycles and snap_regs retained; timed_out retained; snap_valid=0.
  - abort has priority over start and over halt/watchdog.
- Async reset mid-run: immediate IDLE, all outputs to reset values.
- Latencies:
  - start to core_rst_n=1 is RST_HOLD+1 cycles.
  - Halt detect to snap_valid is 2 cycles.

Decomposition:
- Shared package run_ctrl_pkg: state encoding constants (IDLE=0, HOLD=1, RUN=2, CAPTURE=3, DONE=4, 3 bits) and parameter legality checks (sim-only assertions under `sim).
- One natural sub-module, pc_stall_detector: previous-pc register, saturating stall counter, stall flag. All other logic stays inline.

Test Plan:
- Reset, then start pulse, core pc increments every cycle, halt_req at RUN cycle 10 -> core_rst_n low 2 cycles, cycles=10, timed_out=0, done=1, snap_valid single pulse 2 cycles later, snap_regs==regs_flat as sampled in CAPTURE.
- PC stuck at 6'h14 from RUN cycle 5 onward -> halt after 3 equal samples; cycles=7, timed_out=0.
- pc toggles forever, no halt -> cycles=1001, timed_out=1, done=1.
- halt_req asserted exactly when cycles reaches TIMEOUT -> timed_out=0, cycles=1001.
- abort during RUN at cycle 50 -> IDLE next cycle, core_rst_n=0, cycles=50 retained, snap_valid never pulses.
- From DONE, start again -> cycles cleared to 0 and a second run completes independently; rst pulsed low mid-RUN -> all outputs zero immediately.
